id_ex_stage: RTL and testbench

- Parametrised pipelined decode stage for the MIPS core.
- Contains:
  - an NREGS-entry register file with a same-cycle write-to-read bypass;
  - the write-register selection;
  - sign and shamt extension;
  - load-use hazard detection;
  - the ID/EX pipeline register, with stall and flush.
- Sits between IF/ID and EX. The control unit stays external and feeds a packed control bundle.

---
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundles every non-clock signal of the decode stage into one interface.
//   master : the upstream/testbench side. It drives the IF/ID fields, the
//            control-unit decode bits, flush and write-back. It observes the
//            ID/EX register, stall and stall_count.
//   slave  : the id_ex_stage side, with the opposite directions.
// Parameters must match the ones given to id_ex_stage.
interface id_ex_stage_if #(
  parameter int NBITS     = 32,
  parameter int NREGS     = 32,
  parameter int CTRL_BITS = 16
);
  localparam int AW = $clog2(NREGS);

  // IF/ID and control-unit inputs
  logic                 id_valid;
  logic [NBITS-1:0]     instruction_in;
  logic [NBITS-1:0]     pc_plus4_in;
  logic [CTRL_BITS-1:0] ctrl_in;
  logic                 id_reg_dst;
  logic                 id_link;
  logic                 id_mem_read;
  logic                 id_reg_write;
  logic                 id_uses_rt;
  logic                 flush;

  // write-back port
  logic                 wb_reg_write;
  logic [AW-1:0]        wb_write_register;
  logic [NBITS-1:0]     wb_write_data;

  // hazard and ID/EX outputs
  logic                 stall;
  logic                 ex_valid;
  logic [NBITS-1:0]     ex_read_data1;
  logic [NBITS-1:0]     ex_read_data2;
  logic [NBITS-1:0]     ex_imm_ext;
  logic [NBITS-1:0]     ex_shamt_ext;
  logic [AW-1:0]        ex_rs;
  logic [AW-1:0]        ex_rt;
  logic [AW-1:0]        ex_dest_reg;
  logic [NBITS-1:0]     ex_pc_plus4;
  logic [CTRL_BITS-1:0] ex_ctrl;
  logic                 ex_mem_read;
  logic                 ex_reg_write;
  logic [31:0]          stall_count;

  modport master (
    output id_valid, instruction_in, pc_plus4_in, ctrl_in, id_reg_dst,
           id_link, id_mem_read, id_reg_write, id_uses_rt, flush,
           wb_reg_write, wb_write_register, wb_write_data,
    input  stall, ex_valid, ex_read_data1, ex_read_data2, ex_imm_ext,
           ex_shamt_ext, ex_rs, ex_rt, ex_dest_reg, ex_pc_plus4, ex_ctrl,
           ex_mem_read, ex_reg_write, stall_count
  );

  modport slave (
    input  id_valid, instruction_in, pc_plus4_in, ctrl_in, id_reg_dst,
           id_link, id_mem_read, id_reg_write, id_uses_rt, flush,
           wb_reg_write, wb_write_register, wb_write_data,
    output stall, ex_valid, ex_read_data1, ex_read_data2, ex_imm_ext,
           ex_shamt_ext, ex_rs, ex_rt, ex_dest_reg, ex_pc_plus4, ex_ctrl,
           ex_mem_read, ex_reg_write, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
// MIPS decode stage. It contains:
//   - the register file, with a write-to-read bypass;
//   - destination-register selection;
//   - immediate and shamt extension;
//   - load-use hazard detection;
//   - the ID/EX pipeline register, with flush and stall.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears the register file, ID/EX and
//           the stall counter
//   bus   : id_ex_stage_if.slave. It carries the IF/ID and control inputs,
//           the write-back port, stall, the ex_* outputs and stall_count.
// Optional feature:
//   Define ID_STALL_COUNTER_EN to build a saturating 32-bit counter of
//   stalled cycles. Without it, stall_count is tied to zero.
module id_ex_stage #(
  parameter int NBITS     = 32,
  parameter int NREGS     = 32,
  parameter int CTRL_BITS = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic                 valid;
    logic                 memRead;
    logic                 regWrite;
    logic [CTRL_BITS-1:0] ctrl;
    logic [NBITS-1:0]     readData1;
    logic [NBITS-1:0]     readData2;
    logic [NBITS-1:0]     immExt;
    logic [NBITS-1:0]     shamtExt;
    logic [NBITS-1:0]     pcPlus4;
    logic [AW-1:0]        rs;
    logic [AW-1:0]        rt;
    logic [AW-1:0]        destReg;
  } exStage_t;

  logic [NBITS-1:0] regs_q [NREGS];
  exStage_t         exStage_q, exStage_d;
  logic [AW-1:0]    rsIdx, rtIdx, rdIdx, destReg;
  logic [NBITS-1:0] rsData, rtData;
  logic             wbActive;
  logic             stallHazard;
  logic             unusedInstrBits;

  // Only the low AW bits of each register field are decoded.
  assign rsIdx = bus.instruction_in[21 +: AW];
  assign rtIdx = bus.instruction_in[16 +: AW];
  assign rdIdx = bus.instruction_in[11 +: AW];
  assign unusedInstrBits = ^bus.instruction_in;

  // A write-back to r0 is dropped entirely. It neither stores nor bypasses.
  assign wbActive = bus.wb_reg_write && (bus.wb_write_register != '0);

  // Register file storage. r0 is never written, so it stays at its reset
  // value of zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wbActive) begin
      regs_q[bus.wb_write_register] <= bus.wb_write_data;
    end
  end

  // Combinational reads. Write-back data for the same address wins over the
  // stored value, so an instruction decoded in the write-back cycle sees it.
  always_comb begin
    rsData = regs_q[rsIdx];
    rtData = regs_q[rtIdx];
    if (wbActive && (bus.wb_write_register == rsIdx)) rsData = bus.wb_write_data;
    if (wbActive && (bus.wb_write_register == rtIdx)) rtData = bus.wb_write_data;
  end

  // jal links into the last register. Otherwise R-type writes rd and
  // I-type writes rt.
  always_comb begin
    destReg = rtIdx;
    if (bus.id_link)         destReg = AW'(NREGS - 1);
    else if (bus.id_reg_dst) destReg = rdIdx;
  end

  // A load in EX whose result is needed by the instruction in ID must hold
  // ID for one cycle. rt only counts when the instruction really reads it.
  assign stallHazard = bus.id_valid && exStage_q.valid && exStage_q.memRead &&
                       (exStage_q.destReg != '0) &&
                       ((exStage_q.destReg == rsIdx) ||
                        (bus.id_uses_rt && (exStage_q.destReg == rtIdx)));
  assign bus.stall = stallHazard;

  // Next ID/EX contents. Flush, stall and an empty IF/ID all insert an
  // all-zero bubble. Otherwise the decoded instruction is captured.
  always_comb begin
    exStage_d = '0;
    if (!bus.flush && !stallHazard && bus.id_valid) begin
      exStage_d.valid     = 1'b1;
      exStage_d.memRead   = bus.id_mem_read;
      exStage_d.regWrite  = bus.id_reg_write;
      exStage_d.ctrl      = bus.ctrl_in;
      exStage_d.readData1 = rsData;
      exStage_d.readData2 = rtData;
      exStage_d.immExt    = {{(NBITS-16){bus.instruction_in[15]}}, bus.instruction_in[15:0]};
      exStage_d.shamtExt  = {{(NBITS-5){1'b0}}, bus.instruction_in[10:6]};
      exStage_d.pcPlus4   = bus.pc_plus4_in;
      exStage_d.rs        = rsIdx;
      exStage_d.rt        = rtIdx;
      exStage_d.destReg   = destReg;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) exStage_q <= '0;
    else       exStage_q <= exStage_d;
  end

  assign bus.ex_valid      = exStage_q.valid;
  assign bus.ex_mem_read   = exStage_q.memRead;
  assign bus.ex_reg_write  = exStage_q.regWrite;
  assign bus.ex_ctrl       = exStage_q.ctrl;
  assign bus.ex_read_data1 = exStage_q.readData1;
  assign bus.ex_read_data2 = exStage_q.readData2;
  assign bus.ex_imm_ext    = exStage_q.immExt;
  assign bus.ex_shamt_ext  = exStage_q.shamtExt;
  assign bus.ex_pc_plus4   = exStage_q.pcPlus4;
  assign bus.ex_rs         = exStage_q.rs;
  assign bus.ex_rt         = exStage_q.rt;
  assign bus.ex_dest_reg   = exStage_q.destReg;

`ifdef ID_STALL_COUNTER_EN
  logic [31:0] stallCount_q;

  // Counts stalled cycles. It saturates instead of wrapping, so a long run
  // never reports a deceptively small number.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  stallCount_q <= '0;
    else if (stallHazard && (stallCount_q != '1)) stallCount_q <= stallCount_q + 32'd1;
  end

  assign bus.stall_count = stallCount_q;
`else
  assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed testbench for id_ex_stage with the default parameters
// (32-bit datapath, 32 registers, 16-bit control bundle).
// Covered scenarios:
//   - reset behaviour;
//   - register-file bypass and writes to r0;
//   - load-use stalls, including reset during a stall;
//   - flush, with and without a simultaneous stall;
//   - destination select and immediate/shamt extension;
//   - the stall counter, in whichever build variant is compiled.
// Compile with ID_STALL_COUNTER_EN defined to exercise the counter.
module tb_id_ex_stage;
  logic clk;
  logic reset;
  int   totalChecks;
  int   badChecks;

  id_ex_stage_if #(.NBITS(32), .NREGS(32), .CTRL_BITS(16)) bus ();

  id_ex_stage #(.NBITS(32), .NREGS(32), .CTRL_BITS(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit, so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt);
    return {6'd0, rs, rt, rd, shamt, 6'h20};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID-side inputs of one instruction.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [15:0] ctrl,
                               input logic regDst, input logic link,
                               input logic memRead, input logic regWrite,
                               input logic usesRt);
    bus.id_valid       = valid;
    bus.instruction_in = instr;
    bus.pc_plus4_in    = pc;
    bus.ctrl_in        = ctrl;
    bus.id_reg_dst     = regDst;
    bus.id_link        = link;
    bus.id_mem_read    = memRead;
    bus.id_reg_write   = regWrite;
    bus.id_uses_rt     = usesRt;
  endtask

  task automatic driveWb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_reg_write      = we;
    bus.wb_write_register = addr;
    bus.wb_write_data     = data;
  endtask

  // Outputs stay zero while reset is held with busy inputs. After a
  // register has been written, a reset wipes it: every register then
  // reads zero through both ports.
  task automatic test_reset();
    reset = 1'b1;
    bus.flush = 1'b0;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    driveWb(1'b1, 5'd5, 32'hAAAA_5555);
    tick();
    tick();
    totalChecks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_flags: got %b%b%b expected 000", bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write);
    end
    totalChecks++;
    if (bus.ex_ctrl !== 16'h0 || bus.ex_pc_plus4 !== 32'h0 || bus.ex_imm_ext !== 32'h0 ||
        bus.ex_read_data1 !== 32'h0 || bus.ex_dest_reg !== 5'd0) begin
      badChecks++;
      $display("[TB] FAIL reset_fields: got ctrl=%h pc=%h imm=%h rd1=%h dest=%0d expected all 0",
               bus.ex_ctrl, bus.ex_pc_plus4, bus.ex_imm_ext, bus.ex_read_data1, bus.ex_dest_reg);
    end
    totalChecks++;
    if (bus.stall !== 1'b0 || bus.stall_count !== 32'd0) begin
      badChecks++;
      $display("[TB] FAIL reset_stall: got stall=%b count=%0d expected 0 0", bus.stall, bus.stall_count);
    end
    // store r5, then reset again to check that the register file clears
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    driveWb(1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, rType(5'(i), 5'(i), 5'd1, 5'd0), 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      totalChecks++;
      if (bus.ex_read_data1 !== 32'h0 || bus.ex_read_data2 !== 32'h0) begin
        badChecks++;
        $display("[TB] FAIL reset_regread r%0d: got %h/%h expected 0/0", i, bus.ex_read_data1, bus.ex_read_data2);
      end
    end
  endtask

  // Write-back data must reach an instruction decoded in the same cycle,
  // and it must also be stored. Writes to r0 must have no effect at all.
  task automatic test_bypass();
    driveWb(1'b1, 5'd5, 32'hDEAD_BEEF);
    applyStimulus(1'b1, rType(5'd5, 5'd0, 5'd2, 5'd0), 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    totalChecks++;
    if (bus.ex_read_data1 !== 32'hDEAD_BEEF || bus.ex_rs !== 5'd5) begin
      badChecks++;
      $display("[TB] FAIL bypass_rs: got %h rs=%0d expected deadbeef rs=5", bus.ex_read_data1, bus.ex_rs);
    end
    driveWb(1'b1, 5'd7, 32'h0000_0077);
    applyStimulus(1'b1, rType(5'd5, 5'd7, 5'd2, 5'd0), 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    totalChecks++;
    if (bus.ex_read_data1 !== 32'hDEAD_BEEF || bus.ex_read_data2 !== 32'h0000_0077) begin
      badChecks++;
      $display("[TB] FAIL bypass_stored_rt: got %h/%h expected deadbeef/00000077", bus.ex_read_data1, bus.ex_read_data2);
    end
    driveWb(1'b1, 5'd0, 32'h0000_1234);
    applyStimulus(1'b1, rType(5'd0, 5'd0, 5'd2, 5'd0), 32'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    totalChecks++;
    if (bus.ex_read_data1 !== 32'h0 || bus.ex_read_data2 !== 32'h0) begin
      badChecks++;
      $display("[TB] FAIL r0_bypass: got %h/%h expected 0/0", bus.ex_read_data1, bus.ex_read_data2);
    end
    driveWb(1'b0, 5'd0, 32'h0);
    tick();
    totalChecks++;
    if (bus.ex_read_data1 !== 32'h0) begin
      badChecks++;
      $display("[TB] FAIL r0_stored: got %h expected 0", bus.ex_read_data1);
    end
  endtask

  // A load in EX followed by a dependent add must stall once. One bubble
  // is inserted and then the add proceeds. An rt match only stalls when rt
  // is actually used, a load into r0 never stalls, and reset drops the
  // stall at once.
  task automatic test_load_use();
    applyStimulus(1'b1, iType(6'h23, 5'd1, 5'd8, 16'h4), 32'h100, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    totalChecks++;
    if (bus.ex_mem_read !== 1'b1 || bus.ex_dest_reg !== 5'd8) begin
      badChecks++;
      $display("[TB] FAIL lw_in_ex: got mr=%b dest=%0d expected 1 8", bus.ex_mem_read, bus.ex_dest_reg);
    end
    applyStimulus(1'b1, rType(5'd8, 5'd2, 5'd3, 5'd0), 32'h104, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    totalChecks++;
    if (bus.stall !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL loaduse_stall: got %b expected 1", bus.stall);
    end
    tick();
    totalChecks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.stall !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL loaduse_bubble: got v=%b mr=%b stall=%b expected 0 0 0", bus.ex_valid, bus.ex_mem_read, bus.stall);
    end
    tick();
    totalChecks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd8 || bus.ex_dest_reg !== 5'd3) begin
      badChecks++;
      $display("[TB] FAIL loaduse_release: got v=%b rs=%0d dest=%0d expected 1 8 3", bus.ex_valid, bus.ex_rs, bus.ex_dest_reg);
    end
    // rt match without id_uses_rt
    applyStimulus(1'b1, iType(6'h23, 5'd1, 5'd8, 16'h4), 32'h108, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, rType(5'd1, 5'd8, 5'd3, 5'd0), 32'h10C, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    totalChecks++;
    if (bus.stall !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL rt_unused_nostall: got %b expected 0", bus.stall);
    end
    bus.id_uses_rt = 1'b1;
    #1;
    totalChecks++;
    if (bus.stall !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL rt_used_stall: got %b expected 1", bus.stall);
    end
    // reset during the stall
    reset = 1'b1;
    #1;
    totalChecks++;
    if (bus.stall !== 1'b0 || bus.ex_valid !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL reset_midstall: got stall=%b v=%b expected 0 0", bus.stall, bus.ex_valid);
    end
    reset = 1'b0;
    // load into r0
    applyStimulus(1'b1, iType(6'h23, 5'd1, 5'd0, 16'h4), 32'h110, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, rType(5'd0, 5'd0, 5'd3, 5'd0), 32'h114, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    totalChecks++;
    if (bus.stall !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL lw_r0_nostall: got %b expected 0", bus.stall);
    end
  endtask

  // Flush squashes a valid instruction into a bubble. Without flush the
  // control bundle and PC+4 pass through. Flush together with a stall still
  // gives a bubble while stall stays high, and an empty IF/ID also gives a
  // bubble.
  task automatic test_flush();
    bus.flush = 1'b1;
    applyStimulus(1'b1, rType(5'd1, 5'd2, 5'd3, 5'd0), 32'h200, 16'hABCD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    totalChecks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_ctrl !== 16'h0) begin
      badChecks++;
      $display("[TB] FAIL flush_bubble: got v=%b rw=%b ctrl=%h expected 0 0 0000", bus.ex_valid, bus.ex_reg_write, bus.ex_ctrl);
    end
    bus.flush = 1'b0;
    tick();
    totalChecks++;
    if (bus.ex_valid !== 1'b1 || bus.ex_reg_write !== 1'b1 || bus.ex_ctrl !== 16'hABCD || bus.ex_pc_plus4 !== 32'h200) begin
      badChecks++;
      $display("[TB] FAIL noflush_pass: got v=%b rw=%b ctrl=%h pc=%h expected 1 1 abcd 00000200",
               bus.ex_valid, bus.ex_reg_write, bus.ex_ctrl, bus.ex_pc_plus4);
    end
    applyStimulus(1'b1, iType(6'h23, 5'd1, 5'd8, 16'h4), 32'h204, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, rType(5'd8, 5'd2, 5'd3, 5'd0), 32'h208, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.flush = 1'b1;
    #1;
    totalChecks++;
    if (bus.stall !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL flush_stall_asserts: got %b expected 1", bus.stall);
    end
    tick();
    totalChecks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 16'h0) begin
      badChecks++;
      $display("[TB] FAIL flush_stall_bubble: got v=%b ctrl=%h expected 0 0000", bus.ex_valid, bus.ex_ctrl);
    end
    bus.flush = 1'b0;
    applyStimulus(1'b0, rType(5'd1, 5'd2, 5'd3, 5'd0), 32'h20C, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    totalChecks++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL idle_bubble: got v=%b rw=%b expected 0 0", bus.ex_valid, bus.ex_reg_write);
    end
  endtask

  // Destination select for jal, R-type and I-type, plus sign extension of
  // the immediate and zero extension of shamt.
  task automatic test_dest_select();
    applyStimulus(1'b1, 32'h0C00_1234, 32'h300, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    totalChecks++;
    if (bus.ex_dest_reg !== 5'd31) begin
      badChecks++;
      $display("[TB] FAIL dest_jal: got %0d expected 31", bus.ex_dest_reg);
    end
    applyStimulus(1'b1, rType(5'd3, 5'd4, 5'd12, 5'd5), 32'h304, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    totalChecks++;
    if (bus.ex_dest_reg !== 5'd12 || bus.ex_rt !== 5'd4) begin
      badChecks++;
      $display("[TB] FAIL dest_rtype: got dest=%0d rt=%0d expected 12 4", bus.ex_dest_reg, bus.ex_rt);
    end
    totalChecks++;
    if (bus.ex_shamt_ext !== 32'd5) begin
      badChecks++;
      $display("[TB] FAIL shamt_ext: got %h expected 00000005", bus.ex_shamt_ext);
    end
    applyStimulus(1'b1, iType(6'h08, 5'd2, 5'd9, 16'h8001), 32'h308, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    totalChecks++;
    if (bus.ex_dest_reg !== 5'd9) begin
      badChecks++;
      $display("[TB] FAIL dest_itype: got %0d expected 9", bus.ex_dest_reg);
    end
    totalChecks++;
    if (bus.ex_imm_ext !== 32'hFFFF_8001) begin
      badChecks++;
      $display("[TB] FAIL imm_neg: got %h expected ffff8001", bus.ex_imm_ext);
    end
    applyStimulus(1'b1, iType(6'h08, 5'd2, 5'd9, 16'h7FFF), 32'h30C, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    totalChecks++;
    if (bus.ex_imm_ext !== 32'h0000_7FFF) begin
      badChecks++;
      $display("[TB] FAIL imm_pos: got %h expected 00007fff", bus.ex_imm_ext);
    end
  endtask

  // Three separate load-use stalls. With the counter built, it ends at 3
  // and reset clears it. Without the counter, stall_count stays zero.
  task automatic test_stall_counter();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, iType(6'h23, 5'd1, 5'd8, 16'h4), 32'h400, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, rType(5'd8, 5'd2, 5'd3, 5'd0), 32'h404, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef ID_STALL_COUNTER_EN
    totalChecks++;
    if (bus.stall_count !== 32'd3) begin
      badChecks++;
      $display("[TB] FAIL stall_count_three: got %0d expected 3", bus.stall_count);
    end
    reset = 1'b1;
    #1;
    totalChecks++;
    if (bus.stall_count !== 32'd0) begin
      badChecks++;
      $display("[TB] FAIL stall_count_reset: got %0d expected 0", bus.stall_count);
    end
    reset = 1'b0;
`else
    totalChecks++;
    if (bus.stall_count !== 32'd0) begin
      badChecks++;
      $display("[TB] FAIL stall_count_tied: got %0d expected 0", bus.stall_count);
    end
`endif
  endtask

  // Run the scenarios in sequence, then print the summary.
  initial begin
    totalChecks = 0;
    badChecks   = 0;
    reset       = 1'b1;
    bus.flush   = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    driveWb(1'b0, 5'd0, 32'h0);
    test_reset();
    test_bypass();
    test_load_use();
    test_flush();
    test_dest_select();
    test_stall_counter();
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end
endmodule
